uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, 32, master address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, 32, master data width.
REQ-003 SHALL have parameter BASE_ADDR, 0, bridge base byte address.
REQ-004 SHALL have parameter MAX_RETRY, 15, TXBUSY write responses tolerated per byte (1..255).
REQ-005 SHALL have ports clk input 1 (clock) and reset input 1; one clock; reset is synchronous and active-high.
REQ-006 SHALL have req_valid input 2, req_data0/req_data1 input 8 each, req_ready output 2; one byte-stream requester per index.
REQ-007 SHALL have full AXI4-Lite master ports m_axi_aw*/w*/b*/ar*/r* (addr AXI_ADDR_WIDTH, data AXI_DATA_WIDTH, resp 2), mirroring the bridge slave.
REQ-008 SHALL have busy output 1, err_valid output 1, err_src output 1 and err_code output 2.

Function
REQ-009 SHALL run FSM states IDLE, POLL_AR, POLL_R, WR, WAIT_B.
REQ-010 SHALL assert req_ready[i] combinationally only in IDLE, only for the granted index i; a byte is accepted on req_valid[i]&&req_ready[i].
REQ-011 SHALL grant round-robin: a single valid requester wins; with both valid, the index not granted last wins; after reset, index 0 has priority.
REQ-012 SHALL latch the byte and source on acceptance, clear the retry counter and go to POLL_AR.
REQ-013 POLL_AR SHALL hold arvalid=1, araddr=BASE_ADDR+0x08 until arready, then go to POLL_R.
REQ-014 POLL_R SHALL hold rready=1; on rvalid it SHALL go to WR if rdata[0]=0 and rresp=OKAY, else to POLL_AR with no poll limit.
REQ-015 WR SHALL assert awvalid (awaddr=BASE_ADDR+0x00) and wvalid (wdata={zeros,byte}, wstrb if present = 4'b0001) together.
REQ-016 In WR each valid SHALL drop independently on its own handshake; the FSM SHALL enter WAIT_B once both handshakes complete, including in the same cycle.
REQ-017 WAIT_B SHALL hold bready=1; on bvalid: bresp=00 -> IDLE done; bresp=01 (TXBUSY) -> increment retry and go to POLL_AR if retry<MAX_RETRY, else error; any other bresp -> error immediately.
REQ-018 Error SHALL pulse err_valid for one cycle with err_src=source and err_code=bresp, then return to IDLE; the byte is dropped.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 SHALL never have more than one AXI transaction outstanding; awvalid/wvalid/arvalid SHALL not drop before their handshake.

Reset
REQ-021 On reset SHALL enter IDLE with all valid/ready outputs 0, busy=0, err_valid=0, err_src=0, err_code=0, retry=0, round-robin pointer favouring index 0.
REQ-022 Reset mid-transaction SHALL abandon it with no error pulse; outputs SHALL be at reset values on the first cycle after reset is sampled.

Structure
REQ-023 Shared package uart_bridge_pkg SHALL hold register offsets (TXDATA 0x00, RXDATA 0x04, STATUS 0x08), response codes (OKAY 00, TXBUSY 01, SLVERR 10, INVADD 11) and the FSM state enum.
REQ-024 Arbitration SHALL live in sub-module rr_arbiter (2 requesters, grant vector, advance-on-accept input); the FSM and AXI master stay in the top level.

Verification
REQ-025 req_valid=01, data 0x41, STATUS reads 0, bresp 00 -> one AR to 0x08, then AW 0x00 with wdata 0x00000041, no err_valid, busy low after B.
REQ-026 both requesters held valid (0xAA, 0x55) for 4 bytes -> order src 0,1,0,1.
REQ-027 STATUS returns 0x1 three times then 0x0 -> exactly 4 ARs precede the single AW.
REQ-028 bresp=01 every time, MAX_RETRY=15 -> 15 writes, then err_valid 1 cycle, err_code 01, correct err_src.
REQ-029 bresp=11 on first write -> no retry, err_valid with err_code 11; next requester is then served.
REQ-030 awready delayed 3 cycles after wready, then reset asserted in WAIT_B -> WAIT_B entered only after both handshakes; after reset all valids 0, busy 0, no err_valid.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared UART bridge register map, AXI response codes and FSM states
package uart_bridge_pkg;

    localparam logic [7:0] TXDATA_OFF = 8'h00;
    localparam logic [7:0] RXDATA_OFF = 8'h04;
    localparam logic [7:0] STATUS_OFF = 8'h08;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_TXBUSY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_INVADD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        POLL_AR,
        POLL_R,
        WR,
        WAIT_B
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: two-requester round-robin grant, pointer advances only on accept
module rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_last_one;

    // with both requesting, the index not granted last wins
    assign o_grant = (i_req == 2'b11) ? (r_last_one ? 2'b01 : 2'b10) : i_req;

    // remember last served index; reset makes index 0 the favourite
    always_ff @(posedge clk) begin
        if (reset)
            r_last_one <= 1'b1;
        else if (i_advance)
            r_last_one <= o_grant[1];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: arbitrates two byte streams onto a UART bridge via AXI4-Lite
module uart_tx_arbiter
    import uart_bridge_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        MAX_RETRY      = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  req_valid,
    input  logic [7:0]                  req_data0,
    input  logic [7:0]                  req_data1,
    output logic [1:0]                  req_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic                        busy,
    output logic                        err_valid,
    output logic                        err_src,
    output logic [1:0]                  err_code
);

    localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

    state_t     r_state, w_next;
    logic [7:0] r_byte, r_retry, w_retry_inc;
    logic       r_src, r_aw_done, r_w_done, r_err_valid, r_err_src;
    logic [1:0] r_err_code, w_grant;
    logic       w_accept, w_aw_done, w_w_done, w_err, w_unused_rdata;

    rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign req_ready      = (r_state == IDLE) ? w_grant : 2'b00;
    assign w_accept       = |(req_valid & req_ready);
    assign w_retry_inc    = r_retry + 8'd1;
    assign w_aw_done      = r_aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_w_done       = r_w_done | (m_axi_wvalid & m_axi_wready);
    assign w_unused_rdata = ^m_axi_rdata[AXI_DATA_WIDTH-1:1];

    assign m_axi_arvalid = (r_state == POLL_AR);
    assign m_axi_araddr  = BASE_ADDR + AXI_ADDR_WIDTH'(STATUS_OFF);
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (r_state == POLL_R);
    assign m_axi_awvalid = (r_state == WR) && !r_aw_done;
    assign m_axi_awaddr  = BASE_ADDR + AXI_ADDR_WIDTH'(TXDATA_OFF);
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = (r_state == WR) && !r_w_done;
    assign m_axi_wdata   = {{(AXI_DATA_WIDTH-8){1'b0}}, r_byte};
    assign m_axi_wstrb   = (AXI_DATA_WIDTH/8)'(1);
    assign m_axi_bready  = (r_state == WAIT_B);
    assign busy          = (r_state != IDLE);
    assign err_valid     = r_err_valid;
    assign err_src       = r_err_src;
    assign err_code      = r_err_code;

    // state register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    // next state: poll STATUS until TX is free, write the byte, retry on TXBUSY
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            IDLE:    if (w_accept) w_next = POLL_AR;
            POLL_AR: if (m_axi_arready) w_next = POLL_R;
            POLL_R:  if (m_axi_rvalid) w_next = (!m_axi_rdata[0] && m_axi_rresp == RESP_OKAY) ? WR : POLL_AR;
            WR:      if (w_aw_done && w_w_done) w_next = WAIT_B;
            WAIT_B:  if (m_axi_bvalid) begin
                if (m_axi_bresp == RESP_OKAY)
                    w_next = IDLE;
                else if (m_axi_bresp == RESP_TXBUSY && w_retry_inc < MAX_R)
                    w_next = POLL_AR;
                else begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // byte/source latch, retry count, per-channel write handshake flags and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte      <= '0;
            r_src       <= 1'b0;
            r_retry     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_src   <= 1'b0;
            r_err_code  <= '0;
        end else begin
            if (w_accept) begin
                r_byte <= w_grant[1] ? req_data1 : req_data0;
                r_src  <= w_grant[1];
            end
            r_retry     <= w_accept ? '0 :
                           (r_state == WAIT_B && m_axi_bvalid && m_axi_bresp == RESP_TXBUSY) ? w_retry_inc : r_retry;
            r_aw_done   <= (w_next == WR) && w_aw_done;
            r_w_done    <= (w_next == WR) && w_w_done;
            r_err_valid <= w_err;
            if (w_err) begin
                r_err_src  <= r_src;
                r_err_code <= m_axi_bresp;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, polling, retry, error and reset behaviour
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [7:0]  req_data0 = 8'h00, req_data1 = 8'h00;
    logic [1:0]  req_ready;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [31:0] m_axi_rdata = '0;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0, m_axi_rvalid = 0;
    logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
    logic        busy, err_valid, err_src;
    logic [1:0]  err_code;

    uart_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .err_valid(err_valid), .err_src(err_src), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int acc_cnt = 0, ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, err_cnt = 0, aw_only = 0;
    int ar_at_aw = 0, aw_wait = 0;
    int n_busy = 0, r_base = 0, b_base = 0, aw_delay = 0;
    int s_acc, s_ar, s_r, s_aw, s_w, s_b, s_err, s_awo;
    logic [1:0]  b_first = 0, b_rest = 0;
    logic        b_hold = 0;
    logic [31:0] last_araddr = 0, last_awaddr = 0;
    logic [3:0]  last_wstrb = 0;
    logic        last_err_src = 0;
    logic [1:0]  last_err_code = 0;
    logic        src_q [0:63];
    logic [31:0] wdata_q [0:63];

    // slave model: drive responses at negedge, log handshakes that the next posedge will complete
    initial begin
        forever begin
            @(negedge clk);
            m_axi_arready = 1'b1;
            m_axi_rvalid  = m_axi_rready;
            m_axi_rdata   = (r_cnt - r_base < n_busy) ? 32'h1 : 32'h0;
            m_axi_rresp   = 2'b00;
            m_axi_wready  = 1'b1;
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            m_axi_bvalid  = m_axi_bready && !b_hold;
            m_axi_bresp   = (b_cnt == b_base) ? b_first : b_rest;
            #1;
            if (reset) begin
                aw_wait = 0;
            end else begin
                if (|(req_valid & req_ready)) begin
                    if (acc_cnt < 64) src_q[acc_cnt] = req_ready[1];
                    acc_cnt++;
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    last_araddr = m_axi_araddr;
                    ar_cnt++;
                end
                if (m_axi_rvalid && m_axi_rready) r_cnt++;
                if (m_axi_wvalid && m_axi_wready) begin
                    if (w_cnt < 64) wdata_q[w_cnt] = m_axi_wdata;
                    last_wstrb = m_axi_wstrb;
                    w_cnt++;
                end
                if (m_axi_awvalid && !m_axi_wvalid) aw_only++;
                if (m_axi_awvalid && m_axi_awready) begin
                    last_awaddr = m_axi_awaddr;
                    ar_at_aw = ar_cnt;
                    aw_cnt++;
                end
                aw_wait = (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
                if (m_axi_bvalid && m_axi_bready) b_cnt++;
                if (err_valid) begin
                    last_err_src  = err_src;
                    last_err_code = err_code;
                    err_cnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b00;
        b_hold = 1'b0;
        aw_delay = 0;
        n_busy = 0;
        b_first = 2'b00;
        b_rest = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic snap();
        s_acc = acc_cnt; s_ar = ar_cnt; s_r = r_cnt; s_aw = aw_cnt; s_w = w_cnt;
        s_b = b_cnt; s_err = err_cnt; s_awo = aw_only;
        r_base = r_cnt;
        b_base = b_cnt;
    endtask

    task automatic wait_acc(input int n);
        for (int k = 0; k < 500 && acc_cnt < s_acc + n; k++) begin
            @(negedge clk);
            #2;
        end
        chk("accept_count", 32'(acc_cnt - s_acc), 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000 && busy; k++) begin
            @(negedge clk);
            #2;
        end
        chk("idle_reached", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #2;
    endtask

    function automatic logic [31:0] outs();
        return 32'({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready, m_axi_bready,
                    busy, err_valid, err_src, err_code});
    endfunction

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #2;
        chk("reset_outputs", outs(), 32'd0);
        do_reset();

        // single byte from requester 0, straight path
        snap();
        req_data0 = 8'h41;
        @(negedge clk);
        req_valid = 2'b01;
        #2;
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        wait_acc(1);
        req_valid = 2'b00;
        wait_idle();
        chk("t1_ar_count", 32'(ar_cnt - s_ar), 32'd1);
        chk("t1_araddr", last_araddr, 32'h08);
        chk("t1_aw_count", 32'(aw_cnt - s_aw), 32'd1);
        chk("t1_awaddr", last_awaddr, 32'h00);
        chk("t1_wdata", wdata_q[s_w], 32'h41);
        chk("t1_wstrb", 32'(last_wstrb), 32'h1);
        chk("t1_err_count", 32'(err_cnt - s_err), 32'd0);

        // both requesters held: alternate 0,1,0,1
        do_reset();
        snap();
        req_data0 = 8'hAA;
        req_data1 = 8'h55;
        @(negedge clk);
        req_valid = 2'b11;
        wait_acc(4);
        req_valid = 2'b00;
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_src%0d", k), 32'(src_q[s_acc + k]), 32'(k % 2));
            chk($sformatf("t2_wdata%0d", k), wdata_q[s_w + k], (k % 2) ? 32'h55 : 32'hAA);
        end

        // STATUS busy three times: four reads before the one write
        do_reset();
        snap();
        n_busy = 3;
        req_data0 = 8'h5A;
        @(negedge clk);
        req_valid = 2'b01;
        wait_acc(1);
        req_valid = 2'b00;
        wait_idle();
        chk("t3_ar_count", 32'(ar_cnt - s_ar), 32'd4);
        chk("t3_ar_before_aw", 32'(ar_at_aw - s_ar), 32'd4);
        chk("t3_aw_count", 32'(aw_cnt - s_aw), 32'd1);
        chk("t3_wdata", wdata_q[s_w], 32'h5A);

        // TXBUSY forever: 15 writes then error from source 1
        do_reset();
        snap();
        b_first = 2'b01;
        b_rest = 2'b01;
        req_data1 = 8'h33;
        @(negedge clk);
        req_valid = 2'b10;
        wait_acc(1);
        req_valid = 2'b00;
        wait_idle();
        chk("t4_aw_count", 32'(aw_cnt - s_aw), 32'd15);
        chk("t4_b_count", 32'(b_cnt - s_b), 32'd15);
        chk("t4_err_cycles", 32'(err_cnt - s_err), 32'd1);
        chk("t4_err_code", 32'(last_err_code), 32'h1);
        chk("t4_err_src", 32'(last_err_src), 32'h1);

        // INVADD on first write: no retry, then requester 1 is served
        do_reset();
        snap();
        b_first = 2'b11;
        b_rest = 2'b00;
        req_data0 = 8'h11;
        req_data1 = 8'h22;
        @(negedge clk);
        req_valid = 2'b11;
        wait_acc(2);
        req_valid = 2'b00;
        wait_idle();
        chk("t5_aw_count", 32'(aw_cnt - s_aw), 32'd2);
        chk("t5_err_cycles", 32'(err_cnt - s_err), 32'd1);
        chk("t5_err_code", 32'(last_err_code), 32'h3);
        chk("t5_err_src", 32'(last_err_src), 32'h0);
        chk("t5_second_src", 32'(src_q[s_acc + 1]), 32'h1);
        chk("t5_second_wdata", wdata_q[s_w + 1], 32'h22);

        // awready late by 3 cycles, then reset while waiting for B
        do_reset();
        snap();
        aw_delay = 3;
        b_hold = 1'b1;
        req_data0 = 8'h77;
        @(negedge clk);
        req_valid = 2'b01;
        wait_acc(1);
        req_valid = 2'b00;
        for (int k = 0; k < 50 && !m_axi_bready; k++) begin
            @(negedge clk);
            #2;
        end
        chk("t6_in_wait_b", 32'(m_axi_bready), 32'h1);
        chk("t6_w_count", 32'(w_cnt - s_w), 32'd1);
        chk("t6_aw_count", 32'(aw_cnt - s_aw), 32'd1);
        chk("t6_aw_only_cycles", 32'(aw_only - s_awo), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("t6_reset_outputs", outs(), 32'd0);
        reset = 1'b0;
        b_hold = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("t6_no_err", 32'(err_cnt - s_err), 32'd0);
        chk("t6_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
